int_arbiter: RTL
================

Name: int_arbiter

Overview:
- Interrupt arbiter in front of clint. Collects up to SRC_NUM peripheral interrupt lines (timer, uart, gpio, …) and latches rising edges into pending bits.
- Arbitrates round-robin among pending and enabled sources, then drives a single request into clint's int_flag_i.
- Software claims the granted source through a 4-word register window on the peripheral bus and completes it after the handler, using a PLIC-lite claim/complete handshake.

Parameters:
- SRC_NUM, 8, number of interrupt sources; legal range 1..31.
- ID_W, 5, width of the source ID; ID = source index + 1, and 0 means "none".

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- src_i  input  SRC_NUM  raw interrupt lines, synchronous to clk, rising-edge sensitive.
- we_i  input  1  register write strobe.
- re_i  input  1  register read strobe.
- addr_i  input  4  byte address: 0x0 ENABLE, 0x4 PENDING, 0x8 CLAIM, 0xC COMPLETE.
- data_i  input  `CPU_WIDTH  write data.
- data_o  output  `CPU_WIDTH  read data, registered.
- int_flag_o  output  [`INT_BUS]  request to clint; `INT_NONE when idle, bit0 set while requesting.
- irq_id_o  output  ID_W  ID currently requested or in service; 0 otherwise.
- busy_o  output  1  high in state SERVICE.

Behaviour:
- Reset (async, rst_n=0): all state and outputs cleared.
  - Outputs: data_o=0, int_flag_o=`INT_NONE, irq_id_o=0, busy_o=0.
  - Internal: enable=0, pending=0, src_prev=0, rr_ptr=0, state=IDLE.
  - A reset mid-REQ or mid-SERVICE drops the request immediately.
- Edge detect:
  - edge[i] = src_i[i] & ~src_prev[i]; src_prev is registered every cycle.
  - An edge in cycle t sets pending[i] at the end of t.
- Pending clear sources:
  - CLAIM read clears the granted bit.
  - Write-1-to-clear on PENDING clears the written bits.
  - If set and clear hit the same bit in the same cycle, set wins and no edge is lost.
- Arbitration (combinational):
  - cand = pending & enable.
  - Winner = first set bit of cand searching upward from rr_ptr, wrapping at SRC_NUM-1 back to 0.
  - rr_ptr updates to (winner+1) mod SRC_NUM on a successful CLAIM.
- State machine (one-hot, 3 states):
  - IDLE: when cand != 0, latch winner into grant_id, go to REQ. int_flag_o and irq_id_o are registered, so they appear 1 cycle after cand becomes nonzero. Net latency is 2 cycles from the src_i rising edge.
  - REQ: int_flag_o = bit0 set, irq_id_o = grant_id+1.
    - CLAIM read: go to SERVICE, clear pending[grant_id], int_flag_o=`INT_NONE on the next cycle.
    - If enable[grant_id] or pending[grant_id] is cleared by software before the claim: withdraw to IDLE, int_flag_o=`INT_NONE next cycle, re-arbitrate.
  - SERVICE: busy_o=1, irq_id_o holds the ID, and no new request is issued (no nesting).
    - COMPLETE write with data_i[ID_W-1:0] == grant_id+1: go to IDLE.
    - COMPLETE write with a mismatched ID: ignored, stay in SERVICE.
- Register reads (data_o valid the cycle after re_i; holds its value when re_i=0):
  - ENABLE: returns enable, zero-extended.
  - PENDING: returns pending, zero-extended.
  - CLAIM: returns grant_id+1 in REQ, 0 in any other state. A CLAIM read returning 0 has no side effect.
  - COMPLETE: reads 0.
- Register writes (take effect at the clock edge):
  - ENABLE: loads data_i[SRC_NUM-1:0].
  - PENDING: write-1-to-clear.
  - CLAIM: write ignored.
- Simultaneous we_i and re_i to different addresses: both are performed.
- Bits above SRC_NUM: read 0, writes ignored.
- Pending bits keep accumulating in every state; disabled sources stay pending until enabled or cleared.

Test Plan:
- Reset then single source:
  - Stimulus: enable=0x01, pulse src_i[0] at cycle 10.
  - Required: int_flag_o bit0=1 and irq_id_o=1 at cycle 12.
  - Then CLAIM read: data_o=1 next cycle, PENDING=0, busy_o=1.
  - Then COMPLETE write of 1: busy_o=0.
- Round-robin:
  - Stimulus: enable=0xFF, src_i[2] and src_i[5] rise together.
  - Required: first claim returns 3; after complete, second claim returns 6.
  - Then pulse src_i[0] and src_i[6]: next claim returns 7 (rr_ptr=6), then 1.
- Disabled / withdraw:
  - Stimulus: src_i[3] edge with enable=0.
  - Required: PENDING=0x08, int_flag_o=`INT_NONE; after writing enable=0x08, request with ID 4.
  - Then write enable=0 while in REQ: int_flag_o returns to `INT_NONE next cycle and the CLAIM read returns 0.
- Mismatched complete:
  - Stimulus: in SERVICE for ID 2, write COMPLETE=5.
  - Required: busy_o stays 1; writing COMPLETE=2 clears busy_o.
- Set/clear collision:
  - Stimulus: the CLAIM read of ID 1 coincides with a new src_i[0] rising edge.
  - Required: PENDING bit0 remains 1, and a new request for ID 1 follows completion.
- Async reset during SERVICE:
  - Stimulus: drop rst_n mid-cycle while in SERVICE.
  - Required: busy_o, int_flag_o, irq_id_o, PENDING and ENABLE are all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/int_arbiter.sv
// int_arbiter: round-robin interrupt arbiter in front of clint.
// Latches rising edges of the source lines into pending bits and raises one
// request to clint. Software takes the request with a CLAIM read and ends it
// with a COMPLETE write. Only one interrupt is in service at a time.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INT_BUS
`define INT_BUS 7:0
`endif
`ifndef INT_NONE
`define INT_NONE 8'h00
`endif

module int_arbiter #(
  parameter int SRC_NUM = 8,
  parameter int ID_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SRC_NUM-1:0]    src_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [3:0]            addr_i,
  input  logic [`CPU_WIDTH-1:0] data_i,
  output logic [`CPU_WIDTH-1:0] data_o,
  output logic [`INT_BUS]       int_flag_o,
  output logic [ID_W-1:0]       irq_id_o,
  output logic                  busy_o
);

  localparam int CW = `CPU_WIDTH;
  localparam logic [3:0] ADDR_ENABLE   = 4'h0;
  localparam logic [3:0] ADDR_PENDING  = 4'h4;
  localparam logic [3:0] ADDR_CLAIM    = 4'h8;
  localparam logic [3:0] ADDR_COMPLETE = 4'hC;
  localparam logic [SRC_NUM-1:0] ONE_V    = SRC_NUM'(1'b1);
  localparam logic [ID_W-1:0]    LAST_IDX = ID_W'(SRC_NUM - 1);
  localparam logic [ID_W-1:0]    ID_ONE   = ID_W'(1'b1);

  // One-hot encoded so a single flop tells which phase is active.
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    REQ     = 3'b010,
    SERVICE = 3'b100
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [SRC_NUM-1:0]   src_prev_r, enable_r, pending_r;
  logic [ID_W-1:0]      rr_ptr_r, grant_id_r, grant_nxt_s, rr_nxt_s;
  logic [SRC_NUM-1:0]   edge_s, enable_nxt_s, pending_nxt_s, pend_clr_s;
  logic [SRC_NUM-1:0]   cand_s, hi_s, pick_s, win_oh_s, grant_oh_s;
  logic [ID_W-1:0]      win_idx_s, claim_val_s, irq_id_nxt_s;
  logic                 wr_enable_s, wr_pend_s, wr_comp_s, claim_ok_s, comp_ok_s;
  logic [CW-1:0]        rd_data_s;
  logic [`INT_BUS]      int_flag_nxt_s;
  logic                 unused_data_s;

  assign unused_data_s = ^data_i;

  assign edge_s      = src_i & ~src_prev_r;
  assign wr_enable_s = we_i && (addr_i == ADDR_ENABLE);
  assign wr_pend_s   = we_i && (addr_i == ADDR_PENDING);
  assign wr_comp_s   = we_i && (addr_i == ADDR_COMPLETE);
  // Only a claim in REQ has side effects; a claim that reads 0 does nothing.
  assign claim_ok_s  = re_i && (addr_i == ADDR_CLAIM) && (state_r == REQ);
  assign grant_oh_s  = ONE_V << grant_id_r;
  assign claim_val_s = (state_r == REQ) ? (grant_id_r + ID_ONE) : '0;
  assign comp_ok_s   = wr_comp_s && (data_i[ID_W-1:0] == (grant_id_r + ID_ONE));
  assign rr_nxt_s    = (grant_id_r == LAST_IDX) ? '0 : (grant_id_r + ID_ONE);

  // Next enable/pending: an edge in the same cycle as a clear wins.
  always_comb begin
    enable_nxt_s  = wr_enable_s ? data_i[SRC_NUM-1:0] : enable_r;
    pend_clr_s    = (wr_pend_s ? data_i[SRC_NUM-1:0] : '0)
                  | (claim_ok_s ? grant_oh_s : '0);
    pending_nxt_s = (pending_r & ~pend_clr_s) | edge_s;
  end

  // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall.
  always_comb begin
    cand_s    = pending_r & enable_r;
    hi_s      = cand_s & ~((ONE_V << rr_ptr_r) - ONE_V);
    pick_s    = (|hi_s) ? hi_s : cand_s;
    win_oh_s  = pick_s & (~pick_s + ONE_V);
    win_idx_s = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (win_oh_s[i]) begin
        win_idx_s = win_idx_s | ID_W'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  // Next-state logic for the request/service handshake.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_id_r;
    case (state_r)
      IDLE: begin
        if (|cand_s) begin
          state_nxt_s = REQ;
          grant_nxt_s = win_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (claim_ok_s) begin
          state_nxt_s = SERVICE;
        end else if (!(|(enable_nxt_s & grant_oh_s)) || !(|(pending_nxt_s & grant_oh_s))) begin
          // Software disabled or cleared the granted source: withdraw.
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      SERVICE: begin
        if (comp_ok_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVICE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output values computed from the next state so they register with it.
  always_comb begin
    int_flag_nxt_s = `INT_NONE;
    if (state_nxt_s == REQ) begin
      int_flag_nxt_s[0] = 1'b1;
    end else begin
      int_flag_nxt_s = `INT_NONE;
    end
    if (state_nxt_s != IDLE) begin
      irq_id_nxt_s = grant_nxt_s + ID_ONE;
    end else begin
      irq_id_nxt_s = '0;
    end
  end

  // Register read mux; bits above SRC_NUM read back as zero.
  always_comb begin
    rd_data_s = '0;
    case (addr_i)
      ADDR_ENABLE:   rd_data_s = CW'(enable_r);
      ADDR_PENDING:  rd_data_s = CW'(pending_r);
      ADDR_CLAIM:    rd_data_s = CW'(claim_val_s);
      ADDR_COMPLETE: rd_data_s = '0;
      default:       rd_data_s = '0;
    endcase
  end

  // Core state: FSM, grant, enable, pending, edge history and rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_id_r <= '0;
      enable_r   <= '0;
      pending_r  <= '0;
      src_prev_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      state_r    <= state_nxt_s;
      grant_id_r <= grant_nxt_s;
      enable_r   <= enable_nxt_s;
      pending_r  <= pending_nxt_s;
      src_prev_r <= src_i;
      if (claim_ok_s) begin
        rr_ptr_r <= rr_nxt_s;
      end
    end
  end

  // Registered outputs; data_o holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o     <= '0;
      int_flag_o <= `INT_NONE;
      irq_id_o   <= '0;
      busy_o     <= 1'b0;
    end else begin
      if (re_i) begin
        data_o <= rd_data_s;
      end
      int_flag_o <= int_flag_nxt_s;
      irq_id_o   <= irq_id_nxt_s;
      busy_o     <= (state_nxt_s == SERVICE);
    end
  end

endmodule
